ps2_frame_receiver: RTL

Receives PS/2 keyboard device-to-host frames on the raw `ps2Clk`/`ps2Data` pins and delivers each validated scan-code byte to the paddle controller as `code` with a one-cycle `valid` strobe. It sits between the board pins and the key-decode logic. It synchronizes and deglitches the PS/2 clock, shifts in 11-bit frames, and checks start, odd parity and stop bits. An inter-bit watchdog recovers from truncated frames.

---
 rtl/ps2_frame_receiver_pkg.sv | 27 ++
 rtl/ps2_frame_receiver_if.sv | 18 +
 rtl/ps2_frame_receiver_input_filter.sv | 55 +++++
 rtl/ps2_frame_receiver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ps2_frame_receiver_pkg.sv
// Shared PS/2 definitions: receiver FSM states, protocol prefix bytes, the
// default paddle key scan codes and the frame acceptance rule. The key-decode
// logic imports the same constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED = 8'hE0;

  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_O = 8'h44;
  localparam logic [7:0] KEY_L = 8'h4B;

  // A frame is good when data plus parity has odd weight and the stop bit is 1.
  function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                    input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Pin and result bundle of the PS/2 frame receiver.
//   ps2Clk, ps2Data : raw PS/2 pins (driven by the board / master side)
//   code            : last good scan-code byte
//   valid, err      : one-cycle strobes for good / bad frames
//   busy            : a frame is in progress
// The receiver uses the slave modport; whoever drives the pins and consumes
// the codes uses the master modport.
interface ps2_frame_receiver_if;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] code;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (output ps2Clk, ps2Data, input code, valid, err, busy);
  modport slave  (input ps2Clk, ps2Data, output code, valid, err, busy);
endinterface

// File: rtl/ps2_frame_receiver_input_filter.sv
// PS/2 clock conditioning: 2-FF synchronizer, FILTER_LEN-sample deglitcher
// and a falling-edge strobe of the filtered level.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous pin
//   fe       : one-cycle strobe, filtered level was 1 last cycle and is 0 now
module ps2_input_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic fe
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             filt;
  logic             filt_prev;

  // The idle PS/2 clock is high, so everything comes out of reset at 1 to
  // avoid a spurious edge right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      cnt       <= '0;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      // stage p0 -> p1: metastability settling
      sync_p0   <= raw;
      sync_p1   <= sync_p0;
      filt_prev <= filt;
      // The FILTER_LEN-th consecutive disagreeing sample flips the level;
      // any agreeing sample restarts the count.
      if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync_p1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign fe = filt_prev & ~filt;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver. Conditions the raw pins, shifts in
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) on filtered
// falling edges, and reports each good byte with a one-cycle valid strobe.
// An inter-bit watchdog aborts frames whose clock stops.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of ps2_frame_receiver_if (pins in, code/valid/err/busy out)
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input logic                  clk,
  input logic                  rst,
  ps2_frame_receiver_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic fe;
  logic data_p0;
  logic data_p1;

  ps2_state_e      state, state_n;
  logic [7:0]      shreg, shreg_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic            par, par_n;
  logic [WD_W-1:0] wd, wd_n;
  logic [7:0]      code_r, code_n;
  logic            valid_r, valid_n;
  logic            err_r, err_n;
  logic            timeout;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk (clk),
    .rst (rst),
    .raw (bus.ps2Clk),
    .fe  (fe)
  );

  // Data needs no deglitching: it is only looked at on a filtered clock edge,
  // long after it settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= bus.ps2Data;
      data_p1 <= data_p0;
    end
  end

  // A clock edge in the same cycle as the timeout keeps the frame alive.
  assign timeout = (state != IDLE) && !fe && (wd == WD_MAX);

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    code_n    = code_r;
    valid_n   = 1'b0;
    err_n     = 1'b0;

    if (fe || state == IDLE) begin
      wd_n = '0;
    end else if (wd != WD_MAX) begin
      wd_n = wd + 1'b1;
    end else begin
      wd_n = wd;
    end

    case (state)
      IDLE: begin
        if (fe && !data_p1) begin
          shreg_n   = '0;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (fe) begin
          shreg_n   = {data_p1, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      PARITY: begin
        if (fe) begin
          par_n   = data_p1;
          state_n = STOP;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      STOP: begin
        if (fe) begin
          state_n = IDLE;
          if (frame_ok(shreg, par, data_p1)) begin
            code_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      wd      <= '0;
      code_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      par     <= par_n;
      wd      <= wd_n;
      code_r  <= code_n;
      valid_r <= valid_n;
      err_r   <= err_n;
    end
  end

  assign bus.code  = code_r;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;
  assign bus.busy  = (state != IDLE);

endmodule
